// File: rtl/qp_mem_arbiter.sv
// Purpose : share the single-port query-patch SRAM between the accelerator and the Wishbone debug port.
// Latency : the SRAM request mux is combinational; read data and acc_rvalid arrive one cycle after the read.
// Backpres: a request from the non-owner is dropped and counted, never queued; the accelerator sees acc_gnt=0.
//
// Ownership follows wbs_debug. Every handover passes through a drain state, so an open read
// always completes towards the master that issued it.
//   ACC     : the accelerator drives the SRAM (acc_gnt=1)
//   DRAIN_W : nobody drives; wait for !acc_busy and no read in flight, or abort if wbs_debug drops
//   WBS     : the Wishbone port drives the SRAM
//   DRAIN_A : one idle cycle that retires the last Wishbone read
// Ports:
//   wb_clk_i, wb_rst_n_i                      clock, asynchronous active-low reset
//   wbs_debug, wbs_csb0/web0/addr0/wdata0     Wishbone ownership request and SRAM request
//   wbs_rdata0                                read data to wbsCtrl (zero for accelerator reads)
//   acc_csb0/web0/addr0/wdata0, acc_busy      accelerator SRAM request and "operation open" flag
//   acc_gnt, acc_rvalid, acc_rdata0           grant, read-data valid, read data
//   sram_csb0/web0/addr0/wdata0, sram_rdata0  SRAM macro port
//   blk_cnt, blk_clr                          saturating count of refused accelerator requests, clear
// Build option: define QP_ARB_STATS_EN to build the blk_cnt counter; otherwise blk_cnt is 0
// and blk_clr is ignored. Arbitration is the same in both builds.
`timescale 1ns/1ps
module qp_mem_arbiter #(
   parameter int DATA_WIDTH = 11,
   parameter int PATCH_SIZE = 5,
   parameter int NUM_QUERYS = 494,
   parameter int CNT_W      = 16,
   localparam int DW = PATCH_SIZE * DATA_WIDTH,
   localparam int AW = $clog2(NUM_QUERYS)
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_n_i,
   input  logic             wbs_debug,
   input  logic             wbs_csb0,
   input  logic             wbs_web0,
   input  logic [AW-1:0]    wbs_addr0,
   input  logic [DW-1:0]    wbs_wdata0,
   output logic [DW-1:0]    wbs_rdata0,
   input  logic             acc_csb0,
   input  logic             acc_web0,
   input  logic [AW-1:0]    acc_addr0,
   input  logic [DW-1:0]    acc_wdata0,
   input  logic             acc_busy,
   output logic             acc_gnt,
   output logic             acc_rvalid,
   output logic [DW-1:0]    acc_rdata0,
   output logic             sram_csb0,
   output logic             sram_web0,
   output logic [AW-1:0]    sram_addr0,
   output logic [DW-1:0]    sram_wdata0,
   input  logic [DW-1:0]    sram_rdata0,
   output logic [CNT_W-1:0] blk_cnt,
   input  logic             blk_clr
);

   typedef enum logic [1:0] {ST_ACC, ST_DRAIN_W, ST_WBS, ST_DRAIN_A} state_t;

   localparam logic OWN_ACC = 1'b0;
   localparam logic OWN_WBS = 1'b1;

   state_t state;
   logic   rd_inflight;
   logic   rd_owner;
   logic   acc_rd;
   logic   wbs_rd;

   assign acc_gnt = (state == ST_ACC);

   // Only the owner's request reaches the SRAM; in the drain states the port is held idle.
   always_comb begin
      sram_csb0   = 1'b1;
      sram_web0   = 1'b1;
      sram_addr0  = '0;
      sram_wdata0 = '0;
      case (state)
         ST_ACC: begin
            sram_csb0   = acc_csb0;
            sram_web0   = acc_web0;
            sram_addr0  = acc_addr0;
            sram_wdata0 = acc_wdata0;
         end
         ST_WBS: begin
            sram_csb0   = wbs_csb0;
            sram_web0   = wbs_web0;
            sram_addr0  = wbs_addr0;
            sram_wdata0 = wbs_wdata0;
         end
         default: ;
      endcase
   end

   // A read counts only when its issuer currently owns the port.
   assign acc_rd = (state == ST_ACC) && !acc_csb0 && acc_web0;
   assign wbs_rd = (state == ST_WBS) && !wbs_csb0 && wbs_web0;

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state <= ST_ACC;
      end else begin
         case (state)
            ST_ACC:     if (wbs_debug) state <= ST_DRAIN_W;
            // Abort takes priority: if debug is withdrawn the accelerator simply gets the port back.
            ST_DRAIN_W: if (!wbs_debug)                     state <= ST_ACC;
                        else if (!acc_busy && !rd_inflight) state <= ST_WBS;
            ST_WBS:     if (!wbs_debug) state <= ST_DRAIN_A;
            ST_DRAIN_A: state <= ST_ACC;
            default:    state <= ST_ACC;
         endcase
      end
   end

   // The owner is remembered until the next read so the returning data is steered correctly.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         rd_inflight <= 1'b0;
         rd_owner    <= OWN_ACC;
         acc_rvalid  <= 1'b0;
      end else begin
         rd_inflight <= acc_rd || wbs_rd;
         acc_rvalid  <= acc_rd;
         if (acc_rd)      rd_owner <= OWN_ACC;
         else if (wbs_rd) rd_owner <= OWN_WBS;
      end
   end

   assign acc_rdata0 = sram_rdata0;
   // The debug bus must never observe accelerator data.
   assign wbs_rdata0 = (rd_owner == OWN_ACC) ? '0 : sram_rdata0;

`ifdef QP_ARB_STATS_EN
   logic acc_refused;
   logic [CNT_W-1:0] blk_q;

   assign acc_refused = !acc_csb0 && (state != ST_ACC);

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i)                      blk_q <= '0;
      else if (blk_clr)                     blk_q <= '0;
      else if (acc_refused && blk_q != '1)  blk_q <= blk_q + 1'b1;
   end

   assign blk_cnt = blk_q;
`else
   logic unused_blk_clr;
   assign unused_blk_clr = blk_clr;
   assign blk_cnt = '0;
`endif

endmodule

// File: tb/tb_qp_mem_arbiter.sv
// Purpose : self-checking bench for qp_mem_arbiter with a behavioural SRAM behind it.
// Latency : accelerator reads are scoreboarded and matched when acc_rvalid rises.
// Backpres: refused accelerator requests are tracked by a model count compared with blk_cnt.
`timescale 1ns/1ps
module tb_qp_mem_arbiter;
   localparam int DW = 55;
   localparam int AW = 9;
`ifdef QP_ARB_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif
   localparam logic [DW-1:0] W_DATA = 55'h7_FFFF_FFFF_FFFF;

   logic          wb_clk_i = 1'b0;
   logic          wb_rst_n_i;
   logic          wbs_debug, wbs_csb0, wbs_web0;
   logic [AW-1:0] wbs_addr0;
   logic [DW-1:0] wbs_wdata0, wbs_rdata0;
   logic          acc_csb0, acc_web0, acc_busy, acc_gnt, acc_rvalid;
   logic [AW-1:0] acc_addr0;
   logic [DW-1:0] acc_wdata0, acc_rdata0;
   logic          sram_csb0, sram_web0;
   logic [AW-1:0] sram_addr0;
   logic [DW-1:0] sram_wdata0, sram_rdata0;
   logic [15:0]   blk_cnt;
   logic          blk_clr;

   logic          preload;
   logic [DW-1:0] mem [0:511];
   logic [DW-1:0] exp_acc [$];
   int            n_tests = 0;
   int            n_fail  = 0;
   int            exp_blk = 0;
   int            n_hold;

   qp_mem_arbiter dut (
      .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i), .wbs_debug(wbs_debug),
      .wbs_csb0(wbs_csb0), .wbs_web0(wbs_web0), .wbs_addr0(wbs_addr0),
      .wbs_wdata0(wbs_wdata0), .wbs_rdata0(wbs_rdata0),
      .acc_csb0(acc_csb0), .acc_web0(acc_web0), .acc_addr0(acc_addr0),
      .acc_wdata0(acc_wdata0), .acc_busy(acc_busy), .acc_gnt(acc_gnt),
      .acc_rvalid(acc_rvalid), .acc_rdata0(acc_rdata0),
      .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
      .sram_wdata0(sram_wdata0), .sram_rdata0(sram_rdata0),
      .blk_cnt(blk_cnt), .blk_clr(blk_clr)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   // Behavioural SRAM: synchronous write, registered read data.
   always @(posedge wb_clk_i) begin
      if (preload) begin
         mem[5]   <= 55'h1234;
         mem[10]  <= 55'h0ABC;
         mem[493] <= '0;
      end else if (!sram_csb0) begin
         if (!sram_web0) mem[sram_addr0] <= sram_wdata0;
         else            sram_rdata0     <= mem[sram_addr0];
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge wb_clk_i);
      #1;
   endtask

   // Scoreboard side: every acc_rvalid pops the oldest expected accelerator read.
   always @(negedge wb_clk_i) begin
      if (acc_rvalid) begin
         if (exp_acc.size() == 0) chk("acc_rvalid_unexpected", acc_rvalid, 0);
         else                     chk("acc_rdata0", acc_rdata0, exp_acc.pop_front());
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      wb_rst_n_i = 1'b0; preload = 1'b1; blk_clr = 1'b0;
      wbs_debug = 1'b0; wbs_csb0 = 1'b1; wbs_web0 = 1'b1; wbs_addr0 = '0; wbs_wdata0 = '0;
      acc_csb0 = 1'b1; acc_web0 = 1'b1; acc_addr0 = '0; acc_wdata0 = '0; acc_busy = 1'b0;
      repeat (2) cyc();
      preload = 1'b0;
      chk("rst_acc_gnt", acc_gnt, 1);
      chk("rst_acc_rvalid", acc_rvalid, 0);
      chk("rst_blk_cnt", blk_cnt, 0);
      chk("rst_wbs_rdata0", wbs_rdata0, 0);
      wb_rst_n_i = 1'b1;

      // Accelerator read of addr 5
      cyc();
      acc_csb0 = 1'b0; acc_web0 = 1'b1; acc_addr0 = 9'd5;
      exp_acc.push_back(55'h1234);
      #1;
      chk("t1_sram_csb0", sram_csb0, 0);
      chk("t1_sram_addr0", sram_addr0, 5);
      cyc();
      acc_csb0 = 1'b1; acc_addr0 = '0;
      chk("t1_acc_rvalid", acc_rvalid, 1);
      cyc();
      chk("t1_acc_rvalid_off", acc_rvalid, 0);

      // Handover with acc_busy high for 3 cycles; refused acc reads during drain
      for (int i = 0; i < 5; i++) begin
         cyc();
         wbs_debug = 1'b1;
         acc_busy  = (i < 3);
         acc_csb0  = (i >= 1 && i <= 3) ? 1'b0 : 1'b1;
         wbs_csb0 = 1'b0; wbs_web0 = 1'b1; wbs_addr0 = 9'd10;
         if (i >= 1 && i <= 3) exp_blk += STATS;
         #1;
         chk("t2_acc_gnt", acc_gnt, (i == 0));
         chk("t2_sram_csb0", sram_csb0, (i != 4));
         chk("t2_sram_addr0", sram_addr0, (i == 4) ? 10 : 0);
      end
      cyc();
      wbs_csb0 = 1'b1;
      chk("t2_wbs_rdata0", wbs_rdata0, 55'h0ABC);
      chk("t2_blk_cnt", blk_cnt, exp_blk);

      // Wishbone write/readback at the top address with a clashing acc write
      cyc();
      wbs_csb0 = 1'b0; wbs_web0 = 1'b0; wbs_addr0 = 9'd493; wbs_wdata0 = W_DATA;
      acc_csb0 = 1'b0; acc_web0 = 1'b0; acc_addr0 = 9'd493; acc_wdata0 = 55'h5;
      exp_blk += STATS;
      #1;
      chk("t3_sram_web0", sram_web0, 0);
      chk("t3_sram_wdata0", sram_wdata0, W_DATA);
      cyc();
      wbs_web0 = 1'b1;
      acc_csb0 = 1'b1; acc_web0 = 1'b1; acc_addr0 = '0; acc_wdata0 = '0;
      cyc();
      chk("t3_wbs_rdata0", wbs_rdata0, W_DATA);
      chk("t3_acc_rvalid", acc_rvalid, 0);
      chk("t3_blk_cnt", blk_cnt, exp_blk);
      // Last Wishbone read issued as debug drops; it retires in DRAIN_A
      wbs_debug = 1'b0; wbs_addr0 = 9'd10;
      cyc();
      wbs_csb0 = 1'b1;
      chk("t3_drain_a_gnt", acc_gnt, 0);
      chk("t3_drain_a_rdata", wbs_rdata0, 55'h0ABC);
      cyc();
      chk("t3_back_to_acc", acc_gnt, 1);

      // Accelerator read in the same cycle wbs_debug rises
      cyc();
      wbs_debug = 1'b1;
      acc_csb0 = 1'b0; acc_web0 = 1'b1; acc_addr0 = 9'd5;
      exp_acc.push_back(55'h1234);
      cyc();
      acc_csb0 = 1'b1; acc_addr0 = '0;
      chk("t4_acc_rvalid", acc_rvalid, 1);
      chk("t4_wbs_rdata0", wbs_rdata0, 0);
      chk("t4_acc_gnt", acc_gnt, 0);
      wbs_debug = 1'b0;
      repeat (3) cyc();
      chk("t4_return_acc", acc_gnt, 1);
      // Abort from DRAIN_W while the accelerator is still busy
      wbs_debug = 1'b1; acc_busy = 1'b1;
      cyc();
      cyc();
      chk("t4_abort_drain", acc_gnt, 0);
      wbs_debug = 1'b0;
      cyc();
      chk("t4_abort_acc", acc_gnt, 1);
      acc_busy = 1'b0;

      // Saturation and clear of the refused-request counter
      wbs_debug = 1'b1;
      repeat (3) cyc();
      chk("t5_in_wbs", acc_gnt, 0);
      n_hold = (STATS != 0) ? 70000 : 200;
      acc_csb0 = 1'b0; acc_web0 = 1'b1;
      repeat (n_hold) cyc();
      if (STATS != 0) exp_blk = (exp_blk + n_hold > 16'hFFFF) ? 16'hFFFF : exp_blk + n_hold;
      chk("t5_blk_sat", blk_cnt, exp_blk);
      blk_clr = 1'b1;
      cyc();
      blk_clr = 1'b0;
      exp_blk = 0;
      chk("t5_blk_clr", blk_cnt, exp_blk);
      cyc();
      exp_blk = STATS;
      chk("t5_blk_resume", blk_cnt, exp_blk);
      acc_csb0 = 1'b1;

      // Reset during DRAIN_W with an accelerator read in flight
      wbs_debug = 1'b0;
      repeat (3) cyc();
      chk("t6_acc_gnt_pre", acc_gnt, 1);
      wbs_debug = 1'b1;
      acc_csb0 = 1'b0; acc_web0 = 1'b1; acc_addr0 = 9'd5;
      cyc();
      acc_csb0 = 1'b1;
      chk("t6_in_drain", acc_gnt, 0);
      chk("t6_inflight", acc_rvalid, 1);
      #1;
      wb_rst_n_i = 1'b0;
      acc_csb0 = 1'b0;
      #1;
      chk("t6_rst_acc_gnt", acc_gnt, 1);
      chk("t6_rst_acc_rvalid", acc_rvalid, 0);
      chk("t6_rst_blk_cnt", blk_cnt, 0);
      chk("t6_rst_sram_csb0_lo", sram_csb0, 0);
      acc_csb0 = 1'b1;
      #1;
      chk("t6_rst_sram_csb0_hi", sram_csb0, 1);
      cyc();
      wb_rst_n_i = 1'b1; wbs_debug = 1'b0;
      cyc();
      chk("t6_post_rvalid", acc_rvalid, 0);
      chk("t6_post_gnt", acc_gnt, 1);

      chk("scoreboard_empty", exp_acc.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
